quad_debounce: RTL and testbench
================================

QUAD_DEBOUNCE -- requirements
Module: quad_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive clocks a synchronized input must differ from its output before the output follows; legal range 1..255.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of each per-channel stability counter; it SHALL hold DEBOUNCE_CYCLES.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port quadA_raw, input, 1 bit: asynchronous, bouncy encoder channel A.
REQ-006 The block SHALL have port quadB_raw, input, 1 bit: asynchronous, bouncy encoder channel B.
REQ-007 The block SHALL have port quadA, output, 1 bit: debounced channel A, fed to quadrature_clocked.quadA.
REQ-008 The block SHALL have port quadB, output, 1 bit: debounced channel B, fed to quadrature_clocked.quadB.
REQ-009 The block SHALL have port chg, output, 1 bit: one-cycle strobe when quadA and/or quadB updates.
REQ-010 The block SHALL have port err, output, 1 bit: sticky illegal-transition flag; tied 0 unless QUAD_DEBOUNCE_ILLEGAL_DETECT_EN is defined.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each channel SHALL keep a counter that increments every clock where the synchronized value differs from the channel output.
REQ-013 A channel's counter SHALL clear to 0 on any clock where the synchronized value equals the channel output, i.e. on a bounce back.
REQ-014 A channel's output SHALL take the synchronized value, and its counter SHALL clear, on the clock where the counter equals DEBOUNCE_CYCLES-1 and the values still differ.
REQ-015 Latency SHALL be exactly 2+DEBOUNCE_CYCLES clocks from a clean raw edge to the output edge.
REQ-016 With DEBOUNCE_CYCLES=1, an output SHALL follow on the first differing synchronized sample.
REQ-017 Any pulse or bounce shorter than DEBOUNCE_CYCLES synchronized clocks SHALL leave the output unchanged.
REQ-018 chg SHALL be registered, coincident with the output update, and high for exactly 1 cycle, even when both channels update on the same clock.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1, so no wrap-around can occur.

Reset
REQ-020 While reset is high, the synchronizer flops, counters, quadA, quadB, chg and err SHALL all be 0, taking effect asynchronously.
REQ-021 A reset asserted mid-debounce SHALL discard the partial count.
REQ-022 After reset release, a raw level of 1 SHALL reach the output after 2+DEBOUNCE_CYCLES clocks.

Configuration
REQ-023 When macro QUAD_DEBOUNCE_ILLEGAL_DETECT_EN is defined, err SHALL set when quadA and quadB both update on the same clock (a Gray-code violation).
REQ-024 When QUAD_DEBOUNCE_ILLEGAL_DETECT_EN is defined, err SHALL remain set until reset.
REQ-025 When QUAD_DEBOUNCE_ILLEGAL_DETECT_EN is undefined, err SHALL be constant 0 and no detection logic SHALL be synthesized.

Structure
REQ-026 Package quad_pkg SHALL hold QUAD_DEBOUNCE_DEFAULT (16) and QUAD_CNT_W (8), shared with quadrature_clocked benches.
REQ-027 Sub-module debounce_chan (synchronizer, counter, output flop, update strobe) SHALL be instantiated twice.
REQ-028 The top level SHALL OR the two channel strobes into chg and SHALL hold the err logic.
REQ-029 Elaboration SHALL fail if DEBOUNCE_CYCLES is 0 or does not fit in CNT_W.

Verification
REQ-030 Reset, then hold quadA_raw=1 and quadB_raw=0 with DEBOUNCE_CYCLES=4 -> quadA=1 exactly 6 clocks after release, quadB=0, and chg pulses once.
REQ-031 With DEBOUNCE_CYCLES=16, toggle quadA_raw 1->0->1 with 6-clock low phases, repeated 5 times -> quadA never changes and chg is never asserted.
REQ-032 With DEBOUNCE_CYCLES=4, drive the raw sequence 00,10,11,01,00 in 10-clock steps -> the outputs reproduce it, each step 6 clocks late, with 4 single-cycle chg pulses and err=0.
REQ-033 With the macro defined, step raw 00 to 11 in the same clock -> both outputs update on the same clock, chg pulses once, and err=1 stays high until reset.
REQ-034 Assert reset when the quadA count is 3 of 4 -> all outputs are immediately 0, and after release a full 6-clock latency is required again.
REQ-035 With DEBOUNCE_CYCLES=1, apply a raw 0->1 edge -> the output changes 3 clocks later.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg -- shared constants for the quadrature input path.
//   QUAD_DEBOUNCE_DEFAULT : default debounce length in clocks
//   QUAD_CNT_W            : default width of a per-channel stability counter
//   quad_cfg_ok()         : true when a debounce length is legal for a counter width
// Shared with the quadrature_clocked benches so both agree on the defaults.
package quad_pkg;

  localparam int QUAD_DEBOUNCE_DEFAULT = 16;
  localparam int QUAD_CNT_W            = 8;

  // Legal debounce lengths are 1..255 and must be representable in cnt_w bits.
  function automatic bit quad_cfg_ok(input int cycles, input int cnt_w);
    bit fits;
    fits = (cnt_w >= 31) || (cycles < (1 << cnt_w));
    return (cycles >= 1) && (cycles <= 255) && (cnt_w >= 1) && fits;
  endfunction

endpackage

// File: rtl/quad_debounce_chan.sv
// debounce_chan -- one debounced input channel.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   raw    : asynchronous, bouncy input
//   deb    : debounced output
//   upd    : one-cycle strobe, high on the clock where deb changes
// The raw input goes through a 2-flop synchronizer. A stability counter runs
// while the synchronized value differs from deb and clears whenever they
// agree. On the clock where the counter sits at DEBOUNCE_CYCLES-1 and the
// values still differ, deb follows and the counter clears, giving a total
// latency of 2+DEBOUNCE_CYCLES clocks from a clean raw edge.
module debounce_chan
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = QUAD_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = QUAD_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic upd
);

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             diff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], raw};
  end

  assign diff = sync[1] ^ deb;

  // The counter stops at CNT_TC: reaching it with diff still set is the
  // update point, which clears it, so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      deb <= 1'b0;
      upd <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (!diff) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        cnt <= '0;
        deb <= sync[1];
        upd <= 1'b1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/quad_debounce.sv
// quad_debounce -- debouncer for the two channels of a quadrature encoder.
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   quadA_raw  : asynchronous, bouncy channel A
//   quadB_raw  : asynchronous, bouncy channel B
//   quadA      : debounced channel A (to quadrature_clocked.quadA)
//   quadB      : debounced channel B (to quadrature_clocked.quadB)
//   chg        : one-cycle strobe when quadA and/or quadB updates
//   err        : sticky flag, both channels updated on the same clock
// Optional feature macro: QUAD_DEBOUNCE_ILLEGAL_DETECT_EN enables err.
// Without it err is tied low and no detection logic exists.
module quad_debounce
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = QUAD_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = QUAD_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic quadA_raw,
  input  logic quadB_raw,
  output logic quadA,
  output logic quadB,
  output logic chg,
  output logic err
);

  generate
    if (!quad_cfg_ok(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cfg
      $error("quad_debounce: DEBOUNCE_CYCLES must be 1..255 and fit in CNT_W bits");
    end
  endgenerate

  logic upd_a;
  logic upd_b;

  debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk  (clk),
    .reset(reset),
    .raw  (quadA_raw),
    .deb  (quadA),
    .upd  (upd_a)
  );

  debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk  (clk),
    .reset(reset),
    .raw  (quadB_raw),
    .deb  (quadB),
    .upd  (upd_b)
  );

  // Both strobes come straight from flops, so chg stays a single registered
  // pulse aligned with the output update even when both channels move.
  assign chg = upd_a | upd_b;

`ifdef QUAD_DEBOUNCE_ILLEGAL_DETECT_EN
  logic err_q;

  // A Gray-coded encoder never moves both channels at once; latch it until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | (upd_a & upd_b);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_quad_debounce.sv
// tb_quad_debounce -- scoreboard bench for quad_debounce.
// Three instances (DEBOUNCE_CYCLES = 4, 16, 1). Stimulus pushes the expected
// update (cycle, quadA, quadB) into a per-instance queue; a monitor pops and
// compares on every chg strobe.
module tb_quad_debounce;

`ifdef QUAD_DEBOUNCE_ILLEGAL_DETECT_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic a4, b4, a16, b16, a1, b1;
  logic qa4, qb4, chg4, err4;
  logic qa16, qb16, chg16, err16;
  logic qa1, qb1, chg1, err1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int   cyc;
    logic a;
    logic b;
  } exp_t;

  exp_t q4[$];
  exp_t q16[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  quad_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .quadA_raw(a4), .quadB_raw(b4),
    .quadA(qa4), .quadB(qb4), .chg(chg4), .err(err4)
  );

  quad_debounce #(.DEBOUNCE_CYCLES(16), .CNT_W(8)) dut16 (
    .clk(clk), .reset(reset), .quadA_raw(a16), .quadB_raw(b16),
    .quadA(qa16), .quadB(qb16), .chg(chg16), .err(err16)
  );

  quad_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .quadA_raw(a1), .quadB_raw(b1),
    .quadA(qa1), .quadB(qb1), .chg(chg1), .err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // d: 0 -> dut4, 1 -> dut16, 2 -> dut1; lat is cycles after the current one.
  task automatic push(input int d, input int lat, input logic a, input logic b);
    exp_t e;
    e.cyc = cyc + lat;
    e.a   = a;
    e.b   = b;
    case (d)
      0:       q4.push_back(e);
      1:       q16.push_back(e);
      default: q1.push_back(e);
    endcase
  endtask

  task automatic observe(input int d, input logic qa, input logic qb);
    exp_t  e;
    bit    have;
    string nm;
    have = 1'b0;
    case (d)
      0:       begin nm = "d4";  if (q4.size()  > 0) begin e = q4.pop_front();  have = 1'b1; end end
      1:       begin nm = "d16"; if (q16.size() > 0) begin e = q16.pop_front(); have = 1'b1; end end
      default: begin nm = "d1";  if (q1.size()  > 0) begin e = q1.pop_front();  have = 1'b1; end end
    endcase
    if (!have) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_unexpected_chg: got chg=1, expected no update (cycle %0d)", nm, cyc);
    end else begin
      chk({nm, "_chg_cycle"}, cyc, e.cyc);
      chk({nm, "_quadA"}, {31'd0, qa}, {31'd0, e.a});
      chk({nm, "_quadB"}, {31'd0, qb}, {31'd0, e.b});
    end
  endtask

  always @(negedge clk) begin
    if (chg4)  observe(0, qa4, qb4);
    if (chg16) observe(1, qa16, qb16);
    if (chg1)  observe(2, qa1, qb1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d4_out"},  {28'd0, qa4, qb4, chg4, err4}, 32'd0);
    chk({tag, "_d16_out"}, {28'd0, qa16, qb16, chg16, err16}, 32'd0);
    chk({tag, "_d1_out"},  {28'd0, qa1, qb1, chg1, err1}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    a4 = 1'b1; b4 = 1'b0;
    a16 = 1'b1; b16 = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
    step(3);
    chk_all_zero("reset_hold");

    // Release with raw A high: dut4 updates 6 clocks later, dut16 18 later.
    reset = 1'b0;
    push(0, 6, 1'b1, 1'b0);
    push(1, 18, 1'b1, 1'b0);
    step(25);

    // DEBOUNCE_CYCLES=1: every clean edge appears 3 clocks later.
    a1 = 1'b1; push(2, 3, 1'b1, 1'b0); step(5);
    b1 = 1'b1; push(2, 3, 1'b1, 1'b1); step(5);
    a1 = 1'b0; push(2, 3, 1'b0, 1'b1); step(5);
    b1 = 1'b0; push(2, 3, 1'b0, 1'b0); step(5);

    // DEBOUNCE_CYCLES=16: 6-clock low glitches must never get through.
    for (int i = 0; i < 5; i++) begin
      a16 = 1'b0; step(6);
      a16 = 1'b1; step(6);
    end
    chk("d16_glitch_hold", {31'd0, qa16}, 32'd1);
    a16 = 1'b0; push(1, 18, 1'b0, 1'b0);

    // Gray sequence on dut4, starting from state 10.
    a4 = 1'b0; push(0, 6, 1'b0, 1'b0); step(10);
    a4 = 1'b1; push(0, 6, 1'b1, 1'b0); step(10);
    b4 = 1'b1; push(0, 6, 1'b1, 1'b1); step(10);
    a4 = 1'b0; push(0, 6, 1'b0, 1'b1); step(10);
    b4 = 1'b0; push(0, 6, 1'b0, 1'b0); step(10);
    chk("d4_gray_err", {31'd0, err4}, 32'd0);

    // A 3-clock pulse is one short of DEBOUNCE_CYCLES=4 and must be filtered.
    a4 = 1'b1; step(3);
    a4 = 1'b0; step(10);
    chk("d4_short_pulse", {30'd0, qa4, qb4}, 32'd0);

    // Reset with the quadA count at 3 of 4; quadB is high beforehand.
    b4 = 1'b1; push(0, 6, 1'b0, 1'b1); step(10);
    a4 = 1'b1; step(5);
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    step(3);
    reset = 1'b0;
    push(0, 6, 1'b1, 1'b1);
    step(10);
    chk("d4_err_after_both", {31'd0, err4}, {31'd0, ERR_EN});

    // Same-clock 11 -> 00 and 00 -> 11 steps; err stays sticky.
    a4 = 1'b0; b4 = 1'b0; push(0, 6, 1'b0, 1'b0); step(10);
    chk("d4_err_sticky1", {31'd0, err4}, {31'd0, ERR_EN});
    a4 = 1'b1; b4 = 1'b1; push(0, 6, 1'b1, 1'b1); step(10);
    chk("d4_err_sticky2", {31'd0, err4}, {31'd0, ERR_EN});

    reset = 1'b1;
    #1;
    chk("d4_err_cleared", {31'd0, err4}, 32'd0);
    a4 = 1'b0; b4 = 1'b0;
    step(2);
    reset = 1'b0;
    step(10);
    chk("d4_final_out", {29'd0, qa4, qb4, err4}, 32'd0);

    chk("q4_drained",  q4.size(),  32'd0);
    chk("q16_drained", q16.size(), 32'd0);
    chk("q1_drained",  q1.size(),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
